// File: rtl/delay_and_sum_pkg.sv
// delay_and_sum_pkg: shared widths, divider FSM states and magnitude helper
package delay_and_sum_pkg;
  localparam int DS_ACC_WIDTH = 36;
  localparam int DS_WEIGHT_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic logic [63:0] abs_u(input logic signed [63:0] v);
    return v[63] ? 64'(-v) : 64'(v);
  endfunction
endpackage

// File: rtl/delay_and_sum_sdiv_seq_if.sv
// delay_and_sum_sdiv_seq_if: operand and result handshakes of the signed divider
interface delay_and_sum_sdiv_seq_if import delay_and_sum_pkg::*; #(
  parameter int DW = DS_ACC_WIDTH,
  parameter int VW = DS_WEIGHT_WIDTH
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] dividend;
  logic signed [VW-1:0] divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] quotient;
  logic signed [VW-1:0] remainder;
  logic                 div_by_zero;
  logic                 overflow;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/delay_and_sum_udiv_step.sv
// delay_and_sum_udiv_step: one restoring-division step on unsigned magnitudes
module delay_and_sum_udiv_step #(
  parameter int VW = 16
) (
  input  logic [VW:0]   rem,
  input  logic          bit_in,
  input  logic [VW-1:0] dvsr,
  output logic [VW:0]   rem_nxt,
  output logic          q_bit
);
  logic [VW+1:0] sh;
  // shift in the next dividend bit, keep the difference only when it does not go negative
  always_comb begin
    sh = {rem, bit_in};
    q_bit = sh >= (VW+2)'(dvsr);
    rem_nxt = q_bit ? (VW+1)'(sh - (VW+2)'(dvsr)) : sh[VW:0];
  end
endmodule

// File: rtl/delay_and_sum_sdiv_seq.sv
// delay_and_sum_sdiv_seq: iterative signed divider, truncating toward zero
module delay_and_sum_sdiv_seq import delay_and_sum_pkg::*; #(
  parameter int DIVIDEND_WIDTH = DS_ACC_WIDTH,
  parameter int DIVISOR_WIDTH = DS_WEIGHT_WIDTH
) (
  input logic ap_clk,
  input logic ap_rst_n,
  delay_and_sum_sdiv_seq_if.slave bus
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW);
  state_t state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic [VW:0] r, r_nxt;
  logic q_bit, sn, sd, dz, ov;
  delay_and_sum_udiv_step #(.VW(VW)) u_step (
    .rem(r), .bit_in(a[DW-1]), .dvsr(b), .rem_nxt(r_nxt), .q_bit(q_bit)
  );
  assign bus.in_ready = state == IDLE;
  // a shifts dividend magnitude out MSB-first while quotient bits shift in, so it ends as |quotient|;
  // with a zero divisor r simply collects the dividend's low bits, giving the required remainder for free
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      sn <= 1'b0;
      sd <= 1'b0;
      dz <= 1'b0;
      ov <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a <= DW'(abs_u(64'(bus.dividend)));
          b <= VW'(abs_u(64'(bus.divisor)));
          r <= '0;
          cnt <= '0;
          sn <= bus.dividend[DW-1];
          sd <= bus.divisor[VW-1];
          dz <= bus.divisor == '0;
          ov <= bus.dividend == {1'b1, {(DW-1){1'b0}}} && &bus.divisor;
          state <= CALC;
        end
        CALC: begin
          a <= {a[DW-2:0], q_bit};
          r <= r_nxt;
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(DW-1) ? FIX : CALC;
        end
        FIX: begin
          bus.quotient <= dz ? '1 : ov ? a : (sn ^ sd) ? -a : a;
          bus.remainder <= sn ? -r[VW-1:0] : r[VW-1:0];
          bus.div_by_zero <= dz;
          bus.overflow <= ov & ~dz;
          state <= DONE;
        end
        DONE: if (!bus.out_valid) bus.out_valid <= 1'b1;
        else if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_and_sum_sdiv_seq.sv
// tb_delay_and_sum_sdiv_seq: directed and randomized checks against a C-semantics division model
module tb_delay_and_sum_sdiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  delay_and_sum_sdiv_seq_if bus ();
  delay_and_sum_sdiv_seq dut (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] model(input logic signed [35:0] x, input logic signed [15:0] y);
    longint dv, ds, q, r;
    dv = x;
    ds = y;
    if (ds == 0) return {36'hF_FFFF_FFFF, x[15:0], 2'b10};
    if (dv == -(64'sd1 <<< 35) && ds == -1) return {x, 16'h0, 2'b01};
    q = dv / ds;
    r = dv % ds;
    return {q[35:0], r[15:0], 2'b00};
  endfunction

  function automatic logic [53:0] result();
    return {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
  endfunction

  task automatic send(input logic [35:0] x, input logic [15:0] y);
    bus.dividend = x;
    bus.divisor = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_drop", 64'(bus.out_valid), 64'd0);
    check("ready_rise", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run(input string tag, input logic [35:0] x, input logic [15:0] y, input logic [53:0] exp);
    int lat;
    send(x, y);
    wait_out(lat);
    check({tag, "_lat"}, 64'(lat), 64'd38);
    check(tag, 64'(result()), 64'(exp));
    bus.out_ready = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    ack();
  endtask

  initial begin
    int lat, t;
    logic [63:0] w;
    logic [35:0] x;
    logic [15:0] y;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(result()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("p_div_p", 36'd100, 16'd7, {36'd14, 16'd2, 2'b00});
    run("n_div_p", -36'sd100, 16'd7, {36'hF_FFFF_FFF2, 16'hFFFE, 2'b00});
    run("p_div_n", 36'd100, -16'sd7, {36'hF_FFFF_FFF2, 16'd2, 2'b00});
    run("n_div_n", -36'sd100, -16'sd7, {36'd14, 16'hFFFE, 2'b00});
    run("small_num", 36'd7, 16'd100, {36'd0, 16'd7, 2'b00});
    run("div_zero", 36'd12345, 16'd0, {36'hF_FFFF_FFFF, 16'h3039, 2'b10});
    run("div_zero_neg", -36'sd100, 16'd0, {36'hF_FFFF_FFFF, 16'hFF9C, 2'b10});
    run("overflow", 36'h8_0000_0000, 16'hFFFF, {36'h8_0000_0000, 16'h0, 2'b01});
    run("min_by_min", 36'h8_0000_0000, 16'h8000, {36'h0_0010_0000, 16'h0, 2'b00});
    bus.out_ready = 1'b1;
    run("early_ready", 36'd1000, 16'd33, {36'd30, 16'd10, 2'b00});
    send(36'd1000, 16'd9);
    wait_out(lat);
    check("bp_lat", 64'(lat), 64'd38);
    bus.dividend = 36'd500;
    bus.divisor = -16'sd3;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_hold", 64'(result()), 64'({36'd111, 16'd1, 2'b00}));
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_busy", 64'(bus.in_ready), 64'd0);
    end
    ack();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_accept", 64'(bus.in_ready), 64'd0);
    wait_out(lat);
    check("bp2_lat", 64'(lat), 64'd38);
    check("bp2", 64'(result()), 64'({36'hF_FFFF_FF5A, 16'd2, 2'b00}));
    ack();
    send(36'd1000, 16'd3);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_result", 64'(result()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      t += int'(bus.out_valid);
    end
    check("abandoned", 64'(t), 64'd0);
    run("after_rst", 36'd35, 16'd5, {36'd7, 16'd0, 2'b00});
    repeat (1000) begin
      w = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: x = w[35:0];
        1: x = 36'(int'($urandom_range(0, 2000)) - 1000);
        2: x = 36'h8_0000_0000;
        default: x = 36'h7_FFFF_FFFF ^ 36'(w[3:0]);
      endcase
      case ($urandom_range(0, 3))
        0: y = w[51:36];
        1: y = 16'(int'($urandom_range(0, 40)) - 20);
        2: y = 16'h8000;
        default: y = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      bus.out_ready = $urandom_range(0, 1) != 0;
      run("random", x, y, model(x, y));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
